// File: rtl/alu_op_sequencer_if.sv
// Bus between the instruction source / ALU and the op sequencer.
// Groups the instruction handshake, the ALU operand/result bus, the
// retirement status flags and the register-file debug port.
interface alu_op_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 3
);
   logic              InstrValid;
   logic [15:0]       Instr;
   logic              InstrReady;
   logic [DATA_W-1:0] AluA;
   logic [DATA_W-1:0] AluB;
   logic [SEL_W-1:0]  AluSel;
   logic [DATA_W-1:0] AluQ;
   logic              Done;
   logic [DATA_W-1:0] Result;
   logic              Zero;
   logic              Error;
   logic              Halted;
   logic [3:0]        DbgAddr;
   logic [DATA_W-1:0] DbgData;

   // Sequencer side: consumes instructions and the ALU result, drives the rest.
   modport slave (
      input  InstrValid, Instr, AluQ, DbgAddr,
      output InstrReady, AluA, AluB, AluSel, Done, Result, Zero, Error, Halted, DbgData
   );

   // Environment side: instruction source, ALU and debug reader.
   modport master (
      output InstrValid, Instr, AluQ, DbgAddr,
      input  InstrReady, AluA, AluB, AluSel, Done, Result, Zero, Error, Halted, DbgData
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM that owns a shared combinational ALU and a 16x16
// register file. One instruction retires every four cycles:
// IDLE (accept) -> DECODE (read operands) -> EXEC (drive ALU, capture Q)
// -> WRITE (writeback, Done pulse) -> IDLE, or HALTED after a HALT.
module alu_op_sequencer #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   alu_op_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      EXEC,
      WRITE,
      HALTED
   } state_e;

   state_e            state_q;
   logic [15:0]       instr_q;
   logic [DATA_W-1:0] regFile_q [16];
   logic [DATA_W-1:0] aluA_q;
   logic [DATA_W-1:0] aluB_q;
   logic [SEL_W-1:0]  aluSel_q;
   logic [DATA_W-1:0] aluQ_q;
   logic              done_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic              error_q;
   logic              halted_q;

   logic [DATA_W-1:0] aluA_d;
   logic [DATA_W-1:0] aluB_d;
   logic [SEL_W-1:0]  aluSel_d;
   logic              writes_d;
   logic              isHalt_d;
   logic              isIllegal_d;

   logic [3:0] op;
   logic [3:0] rd;
   logic [3:0] ra;
   logic [3:0] rb;

   assign op = instr_q[15:12];
   assign rd = instr_q[11:8];
   assign ra = instr_q[7:4];
   assign rb = instr_q[3:0];

   // Decode the latched instruction into ALU operands/select and writeback
   // class. Ops that do not write drive zero operands with select 0.
   always_comb begin
      aluA_d      = '0;
      aluB_d      = '0;
      aluSel_d    = '0;
      writes_d    = 1'b0;
      isHalt_d    = 1'b0;
      isIllegal_d = 1'b0;
      case (op)
         4'd1, 4'd2, 4'd4, 4'd5, 4'd6: begin
            aluA_d   = regFile_q[ra];
            aluB_d   = regFile_q[rb];
            aluSel_d = SEL_W'(op);
            writes_d = 1'b1;
         end
         4'd3, 4'd7: begin
            aluA_d   = regFile_q[ra];
            aluSel_d = SEL_W'(op);
            writes_d = 1'b1;
         end
         4'd8: begin
            aluA_d   = DATA_W'(instr_q[7:0]);
            aluSel_d = SEL_W'(3);
            writes_d = 1'b1;
         end
         4'd9: begin
            isHalt_d = 1'b1;
         end
         4'd0: begin
         end
         default: begin
            isIllegal_d = 1'b1;
         end
      endcase
   end

   // Sequencer FSM with registered ALU drive, status flags and register file.
   // Done/Error are single-cycle pulses cleared on every other cycle; the
   // writeback lands on the same edge that raises Done.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         aluA_q   <= '0;
         aluB_q   <= '0;
         aluSel_q <= '0;
         aluQ_q   <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         error_q  <= 1'b0;
         halted_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            regFile_q[i] <= '0;
         end
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.InstrValid) begin
                  instr_q <= bus.Instr;
                  state_q <= DECODE;
               end
            end
            DECODE: begin
               aluA_q   <= aluA_d;
               aluB_q   <= aluB_d;
               aluSel_q <= aluSel_d;
               state_q  <= EXEC;
            end
            EXEC: begin
               aluQ_q  <= bus.AluQ;
               state_q <= WRITE;
            end
            WRITE: begin
               done_q  <= 1'b1;
               error_q <= isIllegal_d;
               if (writes_d) begin
                  regFile_q[rd] <= aluQ_q;
                  result_q      <= aluQ_q;
                  zero_q        <= (aluQ_q == '0);
               end else begin
                  result_q <= '0;
                  zero_q   <= 1'b1;
               end
               if (isHalt_d) begin
                  halted_q <= 1'b1;
                  state_q  <= HALTED;
               end else begin
                  state_q <= IDLE;
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.InstrReady = (state_q == IDLE);
   assign bus.AluA       = aluA_q;
   assign bus.AluB       = aluB_q;
   assign bus.AluSel     = aluSel_q;
   assign bus.Done       = done_q;
   assign bus.Result     = result_q;
   assign bus.Zero       = zero_q;
   assign bus.Error      = error_q;
   assign bus.Halted     = halted_q;
   assign bus.DbgData    = regFile_q[bus.DbgAddr];

endmodule
